zsdram_burst_responder: RTL
===========================

ZSDRAM_BURST_RESPONDER -- requirements
Module: zsdram_burst_responder

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, memory read latency in cycles from oMem_Rd issue to iMem_RdData valid (legal 1..7).
REQ-002 SHALL have ports:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  asynchronous, active-high reset
  en  in  1  enable; gates only the start of new transactions
  iRd_Req  in  1  read burst request, held high by requester until oRd_Done
  iRd_Addr  in  24  burst base word address
  oRd_Done  out  1  one-cycle read completion pulse
  oRd_Data1..oRd_Data4  out  16 each  burst words at base+0..base+3
  iWr_Req  in  1  write burst request, held high until oWr_Done
  iWr_Addr  in  24  burst base word address
  iWr_Data1..iWr_Data4  in  16 each  words for base+0..base+3
  oWr_Done  out  1  one-cycle write completion pulse
  oMem_Addr  out  24  memory word address
  oMem_Rd  out  1  read command strobe, one word per cycle
  oMem_Wr  out  1  write command strobe, one word per cycle
  oMem_WrData  out  16  write data, valid with oMem_Wr
  iMem_RdData  in  16  read data, valid RD_LAT cycles after accepted oMem_Rd
  iMem_Busy  in  1  high: memory accepts no command this cycle

Function
REQ-003 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE, GUARD.
REQ-004 In IDLE with en=1, SHALL accept a pending request, latching address (and write data for writes) in the acceptance cycle; with en=0 SHALL remain in IDLE.
REQ-005 When iRd_Req and iWr_Req are both high in IDLE, SHALL grant round-robin: the type not served last; after reset, write wins first.
REQ-006 RD_ISSUE SHALL issue exactly 4 oMem_Rd beats at addresses base, base+1, base+2, base+3, one per cycle with iMem_Busy=0; with iMem_Busy=1, oMem_Rd=0 and beat index/address hold.
REQ-007 Address increment SHALL wrap modulo 2^24 (0xFFFFFF+1 = 0x000000).
REQ-008 SHALL track outstanding reads with an RD_LAT-deep valid pipeline; iMem_RdData captured into oRd_DataN in beat order 1..4 exactly RD_LAT cycles after each accepted beat, independent of iMem_Busy.
REQ-009 After beat 4 issued, SHALL wait in RD_WAIT until the 4th word is captured, then enter DONE.
REQ-010 WR_ISSUE SHALL issue 4 oMem_Wr beats, oMem_WrData = latched Data1..Data4 in order, with the same busy-stall and address rules as reads.
REQ-011 DONE SHALL assert oRd_Done or oWr_Done (matching type) for exactly one cycle; oRd_Data1..4 SHALL be stable from that cycle until the next read's first capture.
REQ-012 GUARD SHALL last one cycle and ignore both requests (requester drops Req the cycle after Done), then return to IDLE.
REQ-013 Minimum latency, iMem_Busy=0: write accept-to-oWr_Done = 5 cycles; read accept-to-oRd_Done = 4+RD_LAT cycles.
REQ-014 oMem_Rd and oMem_Wr SHALL never be high in the same cycle; oMem_Addr/oMem_WrData SHALL be 0 when no strobe is active.
REQ-015 Requests deasserted before Done SHALL NOT abort a transaction; the burst completes and Done pulses.
REQ-016 en=0 mid-transaction SHALL NOT stall or abort it.

Reset
REQ-017 rst=1 SHALL immediately force FSM to IDLE, beat counters and read pipeline to 0, round-robin to write-first, all outputs to 0 (oRd_Done, oWr_Done, oRd_Data1..4, oMem_*).
REQ-018 Reset mid-burst SHALL discard the transaction with no Done; in-flight iMem_RdData returning after reset release SHALL be ignored.

Verification
REQ-019 Write burst: iWr_Addr=0x000100, data 0x1111/0x2222/0x3333/0x4444, busy=0 -> oMem_Wr beats at 0x100..0x103 with those data, oWr_Done single pulse 5 cycles after accept.
REQ-020 Read burst, RD_LAT=2, memory model returning addr[15:0] -> oRd_Data1..4 = 0x0100..0x0103, oRd_Done single pulse 6 cycles after accept.
REQ-021 Simultaneous iRd_Req/iWr_Req held high after reset, repeated three times -> service order W,R,W,R,W,R; one GUARD cycle between each, no double service.
REQ-022 Wrap and stall: iRd_Addr=0xFFFFFE, iMem_Busy high on 2nd beat for 3 cycles -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; data in order; Done delayed by 3 cycles.
REQ-023 rst pulsed during beat 3 of a read -> no oRd_Done, all outputs 0, late iMem_RdData not captured; next request served normally.

Source files
------------

// File: rtl/zsdram_burst_responder_if.sv
// Requester and memory-side signal bundle of the SDRAM burst responder.
// The slave modport is the responder's view; master is the environment's view.
interface zsdram_burst_responder_if;
    logic        en;

    logic        iRd_Req;
    logic [23:0] iRd_Addr;
    logic        oRd_Done;
    logic [15:0] oRd_Data1;
    logic [15:0] oRd_Data2;
    logic [15:0] oRd_Data3;
    logic [15:0] oRd_Data4;

    logic        iWr_Req;
    logic [23:0] iWr_Addr;
    logic [15:0] iWr_Data1;
    logic [15:0] iWr_Data2;
    logic [15:0] iWr_Data3;
    logic [15:0] iWr_Data4;
    logic        oWr_Done;

    logic [23:0] oMem_Addr;
    logic        oMem_Rd;
    logic        oMem_Wr;
    logic [15:0] oMem_WrData;
    logic [15:0] iMem_RdData;
    logic        iMem_Busy;

    modport slave (
        input  en,
        input  iRd_Req, iRd_Addr,
        output oRd_Done, oRd_Data1, oRd_Data2, oRd_Data3, oRd_Data4,
        input  iWr_Req, iWr_Addr, iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4,
        output oWr_Done,
        output oMem_Addr, oMem_Rd, oMem_Wr, oMem_WrData,
        input  iMem_RdData, iMem_Busy
    );

    modport master (
        output en,
        output iRd_Req, iRd_Addr,
        input  oRd_Done, oRd_Data1, oRd_Data2, oRd_Data3, oRd_Data4,
        output iWr_Req, iWr_Addr, iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4,
        input  oWr_Done,
        input  oMem_Addr, oMem_Rd, oMem_Wr, oMem_WrData,
        output iMem_RdData, iMem_Busy
    );
endinterface

// File: rtl/zsdram_burst_responder.sv
// Four-word read/write burst engine between two requesters and a word-wide memory.
// Read data for a beat is sampled on the RD_LAT-th rising edge after the edge that launched it.
module zsdram_burst_responder #(
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    zsdram_burst_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        DONE     = 3'd4,
        GUARD    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic        last_wr_q, last_wr_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  cap_q, cap_d;
    logic [15:0] wdata_q   [4];
    logic [15:0] wdata_d   [4];
    logic [15:0] rd_data_q [4];
    logic [15:0] rd_data_d [4];

    logic mem_rd;
    logic mem_wr;
    logic cap_vld;
    logic last_cap;
    logic grant_wr;

    assign mem_rd   = (state_q == RD_ISSUE) && !bus.iMem_Busy;
    assign mem_wr   = (state_q == WR_ISSUE) && !bus.iMem_Busy;
    assign last_cap = cap_vld && (cap_q == 2'd3);

    // Outstanding-read tracker: one bit per accepted beat, tapped when its data is due.
    generate
        if (RD_LAT <= 1) begin : g_lat1
            assign cap_vld = mem_rd;
        end else begin : g_pipe
            logic [RD_LAT-2:0] rd_pipe_q, rd_pipe_d;

            always_comb begin
                rd_pipe_d    = rd_pipe_q;
                rd_pipe_d[0] = mem_rd;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    rd_pipe_d[i] = rd_pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_pipe_q <= '0;
                end else begin
                    rd_pipe_q <= rd_pipe_d;
                end
            end

            assign cap_vld = rd_pipe_q[RD_LAT-2];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        cap_d     = cap_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        grant_wr  = bus.iWr_Req && (!bus.iRd_Req || !last_wr_q);

        // Captures run independently of the FSM so busy stalls never shift returned data.
        if (cap_vld) begin
            rd_data_d[cap_q] = bus.iMem_RdData;
            cap_d            = cap_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.en && (bus.iRd_Req || bus.iWr_Req)) begin
                    is_wr_d   = grant_wr;
                    last_wr_d = grant_wr;
                    beat_d    = 2'd0;
                    if (grant_wr) begin
                        addr_d     = bus.iWr_Addr;
                        wdata_d[0] = bus.iWr_Data1;
                        wdata_d[1] = bus.iWr_Data2;
                        wdata_d[2] = bus.iWr_Data3;
                        wdata_d[3] = bus.iWr_Data4;
                        state_d    = WR_ISSUE;
                    end else begin
                        addr_d  = bus.iRd_Addr;
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (mem_rd) begin
                    addr_d = addr_q + 24'd1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = last_cap ? DONE : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (last_cap) begin
                    state_d = DONE;
                end
            end
            WR_ISSUE: begin
                if (mem_wr) begin
                    addr_d = addr_q + 24'd1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            last_wr_q <= 1'b0;
            addr_q    <= '0;
            beat_q    <= '0;
            cap_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            cap_q     <= cap_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wdata_q[gi]   <= '0;
                    rd_data_q[gi] <= '0;
                end else begin
                    wdata_q[gi]   <= wdata_d[gi];
                    rd_data_q[gi] <= rd_data_d[gi];
                end
            end
        end
    endgenerate

    assign bus.oMem_Rd     = mem_rd;
    assign bus.oMem_Wr     = mem_wr;
    assign bus.oMem_Addr   = (mem_rd || mem_wr) ? addr_q : 24'd0;
    assign bus.oMem_WrData = mem_wr ? wdata_q[beat_q] : 16'd0;
    assign bus.oRd_Done    = (state_q == DONE) && !is_wr_q;
    assign bus.oWr_Done    = (state_q == DONE) && is_wr_q;
    assign bus.oRd_Data1   = rd_data_q[0];
    assign bus.oRd_Data2   = rd_data_q[1];
    assign bus.oRd_Data3   = rd_data_q[2];
    assign bus.oRd_Data4   = rd_data_q[3];

endmodule
